// File: rtl/xf100_lsu_pkg.sv
// Shared definitions for the xf100 load/store unit: RAM geometry, access
// size encodings, FSM state encoding and the per-size byte-lane pattern.
package xf100_lsu_pkg;

   localparam int XF100_DATA_RAM_AW = 8;

   localparam logic [1:0] XF100_LSU_SIZE_B   = 2'd0;
   localparam logic [1:0] XF100_LSU_SIZE_H   = 2'd1;
   localparam logic [1:0] XF100_LSU_SIZE_W   = 2'd2;
   localparam logic [1:0] XF100_LSU_SIZE_RSV = 2'd3;

   typedef enum logic [2:0] {
      LSU_IDLE = 3'd0,
      LSU_ACC0 = 3'd1,
      LSU_ACC1 = 3'd2,
      LSU_WAIT = 3'd3,
      LSU_RSP  = 3'd4
   } lsu_state_e;

   // Byte-lane pattern of an access before it is shifted to its offset.
   function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
      case (size)
         XF100_LSU_SIZE_B: lsu_size_mask = 4'b0001;
         XF100_LSU_SIZE_H: lsu_size_mask = 4'b0011;
         XF100_LSU_SIZE_W: lsu_size_mask = 4'b1111;
         default:          lsu_size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/xf100_lsu_if.sv
// Execute-stage request/response handshake plus the data RAM port of the
// load/store unit. The slave modport is the LSU's view, master the other side.
interface xf100_lsu_if import xf100_lsu_pkg::*; #(
   parameter int AW = XF100_DATA_RAM_AW
) ();
   logic          lsu_i_valid;
   logic          lsu_o_ready;
   logic          lsu_i_wen;
   logic [1:0]    lsu_i_size;
   logic          lsu_i_unsigned;
   logic [31:0]   lsu_i_addr;
   logic [31:0]   lsu_i_wdata;
   logic          lsu_o_rsp_valid;
   logic          lsu_i_rsp_ready;
   logic [31:0]   lsu_o_rsp_rdata;
   logic          lsu_o_rsp_err;
   logic          lsu_o_ram_cs;
   logic          lsu_o_ram_wen;
   logic [3:0]    lsu_o_ram_mask;
   logic [AW-1:0] lsu_o_ram_addr;
   logic [7:0]    lsu_o_ram_wdat0;
   logic [7:0]    lsu_o_ram_wdat1;
   logic [7:0]    lsu_o_ram_wdat2;
   logic [7:0]    lsu_o_ram_wdat3;
   logic [7:0]    lsu_i_ram_rdat0;
   logic [7:0]    lsu_i_ram_rdat1;
   logic [7:0]    lsu_i_ram_rdat2;
   logic [7:0]    lsu_i_ram_rdat3;

   modport slave (
      input  lsu_i_valid, lsu_i_wen, lsu_i_size, lsu_i_unsigned, lsu_i_addr,
             lsu_i_wdata, lsu_i_rsp_ready,
             lsu_i_ram_rdat0, lsu_i_ram_rdat1, lsu_i_ram_rdat2, lsu_i_ram_rdat3,
      output lsu_o_ready, lsu_o_rsp_valid, lsu_o_rsp_rdata, lsu_o_rsp_err,
             lsu_o_ram_cs, lsu_o_ram_wen, lsu_o_ram_mask, lsu_o_ram_addr,
             lsu_o_ram_wdat0, lsu_o_ram_wdat1, lsu_o_ram_wdat2, lsu_o_ram_wdat3
   );

   modport master (
      output lsu_i_valid, lsu_i_wen, lsu_i_size, lsu_i_unsigned, lsu_i_addr,
             lsu_i_wdata, lsu_i_rsp_ready,
             lsu_i_ram_rdat0, lsu_i_ram_rdat1, lsu_i_ram_rdat2, lsu_i_ram_rdat3,
      input  lsu_o_ready, lsu_o_rsp_valid, lsu_o_rsp_rdata, lsu_o_rsp_err,
             lsu_o_ram_cs, lsu_o_ram_wen, lsu_o_ram_mask, lsu_o_ram_addr,
             lsu_o_ram_wdat0, lsu_o_ram_wdat1, lsu_o_ram_wdat2, lsu_o_ram_wdat3
   );
endinterface

// File: rtl/xf100_lsu_align.sv
// Combinational lane steering: places store data and byte enables onto the
// two words an access may touch, and extracts/extends load data from them.
module xf100_lsu_align import xf100_lsu_pkg::*; (
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_data0,
   output logic [31:0] st_data1,
   output logic [3:0]  st_mask0,
   output logic [3:0]  st_mask1,
   input  logic [31:0] ld_lo,
   input  logic [31:0] ld_hi,
   output logic [31:0] ld_data
);
   logic [31:0] wdata_trim;
   logic [63:0] st_data64;
   logic [7:0]  st_mask8;
   logic [63:0] ld_shift;

   // Store side: drop bytes beyond the access size, then shift onto lanes.
   always_comb begin
      case (size)
         XF100_LSU_SIZE_B: wdata_trim = {24'h0, st_wdata[7:0]};
         XF100_LSU_SIZE_H: wdata_trim = {16'h0, st_wdata[15:0]};
         XF100_LSU_SIZE_W: wdata_trim = st_wdata;
         default:          wdata_trim = 32'h0;
      endcase
      st_data64 = {32'h0, wdata_trim} << {off, 3'b000};
      st_mask8  = {4'h0, lsu_size_mask(size)} << off;
      st_data0  = st_data64[31:0];
      st_data1  = st_data64[63:32];
      st_mask0  = st_mask8[3:0];
      st_mask1  = st_mask8[7:4];
   end

   // Load side: right-justify the addressed bytes and zero/sign extend.
   always_comb begin
      ld_shift = {ld_hi, ld_lo} >> {off, 3'b000};
      case (size)
         XF100_LSU_SIZE_B: ld_data = is_unsigned ? {24'h0, ld_shift[7:0]}
                                                 : {{24{ld_shift[7]}}, ld_shift[7:0]};
         XF100_LSU_SIZE_H: ld_data = is_unsigned ? {16'h0, ld_shift[15:0]}
                                                 : {{16{ld_shift[15]}}, ld_shift[15:0]};
         XF100_LSU_SIZE_W: ld_data = ld_shift[31:0];
         default:          ld_data = 32'h0;
      endcase
   end
endmodule

// File: rtl/xf100_lsu.sv
// Load/store unit: one outstanding byte/half/word access, split into two RAM
// cycles when it straddles a word boundary, answered via valid/ready.
module xf100_lsu import xf100_lsu_pkg::*; #(
   parameter int AW = XF100_DATA_RAM_AW
) (
   input  logic        clk,
   input  logic        rst_n,
   xf100_lsu_if.slave  lsu
);
   lsu_state_e    state_q, state_d;
   logic          wen_q, wen_d;
   logic [1:0]    size_q, size_d;
   logic [1:0]    off_q, off_d;
   logic          uns_q, uns_d;
   logic          split_q, split_d;
   logic          err_q, err_d;
   logic [AW-1:0] word0_q, word0_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   hi_q, hi_d;

   logic          accept;
   logic [1:0]    req_off;
   logic [31:0]   rdat;
   logic [31:0]   st_data0, st_data1, ld_data;
   logic [3:0]    st_mask0, st_mask1;
   logic          unused_addr;

   assign accept      = lsu.lsu_i_valid & (state_q == LSU_IDLE);
   assign req_off     = lsu.lsu_i_addr[1:0];
   assign rdat        = {lsu.lsu_i_ram_rdat3, lsu.lsu_i_ram_rdat2,
                         lsu.lsu_i_ram_rdat1, lsu.lsu_i_ram_rdat0};
   assign unused_addr = ^lsu.lsu_i_addr[31:AW+2];

   xf100_lsu_align u_align (
      .size        (size_q),
      .off         (off_q),
      .is_unsigned (uns_q),
      .st_wdata    (wdata_q),
      .st_data0    (st_data0),
      .st_data1    (st_data1),
      .st_mask0    (st_mask0),
      .st_mask1    (st_mask1),
      .ld_lo       (lo_q),
      .ld_hi       (hi_q),
      .ld_data     (ld_data)
   );

   // Next state, request latching on accept and read-buffer capture.
   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      size_d  = size_q;
      off_d   = off_q;
      uns_d   = uns_q;
      split_d = split_q;
      err_d   = err_q;
      word0_d = word0_q;
      wdata_d = wdata_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               wen_d   = lsu.lsu_i_wen;
               size_d  = lsu.lsu_i_size;
               uns_d   = lsu.lsu_i_unsigned;
               off_d   = req_off;
               word0_d = lsu.lsu_i_addr[AW+1:2];
               wdata_d = lsu.lsu_i_wdata;
               split_d = ((lsu.lsu_i_size == XF100_LSU_SIZE_H) && (req_off == 2'd3)) ||
                         ((lsu.lsu_i_size == XF100_LSU_SIZE_W) && (req_off != 2'd0));
               err_d   = (lsu.lsu_i_size == XF100_LSU_SIZE_RSV);
               state_d = err_d ? LSU_RSP : LSU_ACC0;
            end
         end
         LSU_ACC0: state_d = split_q ? LSU_ACC1 : (wen_q ? LSU_RSP : LSU_WAIT);
         LSU_ACC1: begin
            if (!wen_q) lo_d = rdat;
            state_d = wen_q ? LSU_RSP : LSU_WAIT;
         end
         LSU_WAIT: begin
            if (split_q) hi_d = rdat;
            else         lo_d = rdat;
            state_d = LSU_RSP;
         end
         LSU_RSP:  if (lsu.lsu_i_rsp_ready) state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // Handshake, response and RAM port outputs decoded from the current state.
   always_comb begin
      lsu.lsu_o_ready     = (state_q == LSU_IDLE);
      lsu.lsu_o_rsp_valid = (state_q == LSU_RSP);
      lsu.lsu_o_rsp_err   = (state_q == LSU_RSP) && err_q;
      lsu.lsu_o_rsp_rdata = ((state_q == LSU_RSP) && !wen_q && !err_q) ? ld_data : 32'h0;
      lsu.lsu_o_ram_cs    = 1'b0;
      lsu.lsu_o_ram_wen   = 1'b0;
      lsu.lsu_o_ram_mask  = 4'h0;
      lsu.lsu_o_ram_addr  = '0;
      {lsu.lsu_o_ram_wdat3, lsu.lsu_o_ram_wdat2,
       lsu.lsu_o_ram_wdat1, lsu.lsu_o_ram_wdat0} = 32'h0;
      if (state_q == LSU_ACC0) begin
         lsu.lsu_o_ram_cs   = 1'b1;
         lsu.lsu_o_ram_wen  = wen_q;
         lsu.lsu_o_ram_addr = word0_q;
         if (wen_q) begin
            lsu.lsu_o_ram_mask = st_mask0;
            {lsu.lsu_o_ram_wdat3, lsu.lsu_o_ram_wdat2,
             lsu.lsu_o_ram_wdat1, lsu.lsu_o_ram_wdat0} = st_data0;
         end
      end else if (state_q == LSU_ACC1) begin
         lsu.lsu_o_ram_cs   = 1'b1;
         lsu.lsu_o_ram_wen  = wen_q;
         lsu.lsu_o_ram_addr = word0_q + AW'(1);
         if (wen_q) begin
            lsu.lsu_o_ram_mask = st_mask1;
            {lsu.lsu_o_ram_wdat3, lsu.lsu_o_ram_wdat2,
             lsu.lsu_o_ram_wdat1, lsu.lsu_o_ram_wdat0} = st_data1;
         end
      end
   end

   // State and latch registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LSU_IDLE;
         wen_q   <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= 2'd0;
         uns_q   <= 1'b0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         word0_q <= '0;
         wdata_q <= 32'h0;
         lo_q    <= 32'h0;
         hi_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
         split_q <= split_d;
         err_q   <= err_d;
         word0_q <= word0_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end
endmodule

// File: tb/tb_xf100_lsu.sv
// Directed bench for xf100_lsu: byte-addressed reference memory, response
// scoreboard and a trace of every RAM cycle the unit issues.
module tb_xf100_lsu;
   import xf100_lsu_pkg::*;

   localparam int AW   = XF100_DATA_RAM_AW;
   localparam int MEMB = 4 * (1 << AW);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          wen;
      logic [3:0]    mask;
      logic [31:0]   wdat;
   } ram_cyc_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_init;
   logic [7:0]  ram [0:MEMB-1];
   logic [31:0] ram_rdat_q;
   logic [7:0]  ref_mem [0:MEMB-1];
   ram_cyc_t    trace [$];
   ram_cyc_t    mon_c;
   exp_t        sb [$];
   int          cyc = 0;
   int          t_acc = 0;
   int          checks = 0;
   int          failures = 0;

   xf100_lsu_if #(.AW(AW)) bus ();

   xf100_lsu #(.AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lsu   (bus)
   );

   always #5 clk = ~clk;

   // Cycle counter used to measure response latency.
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM model; read data appears the cycle after a read select.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEMB; i++) ram[i] <= 8'h00;
         ram_rdat_q <= 32'h0;
      end else if (bus.lsu_o_ram_cs) begin
         if (bus.lsu_o_ram_wen) begin
            if (bus.lsu_o_ram_mask[0]) ram[int'(bus.lsu_o_ram_addr)*4+0] <= bus.lsu_o_ram_wdat0;
            if (bus.lsu_o_ram_mask[1]) ram[int'(bus.lsu_o_ram_addr)*4+1] <= bus.lsu_o_ram_wdat1;
            if (bus.lsu_o_ram_mask[2]) ram[int'(bus.lsu_o_ram_addr)*4+2] <= bus.lsu_o_ram_wdat2;
            if (bus.lsu_o_ram_mask[3]) ram[int'(bus.lsu_o_ram_addr)*4+3] <= bus.lsu_o_ram_wdat3;
         end else begin
            ram_rdat_q <= {ram[int'(bus.lsu_o_ram_addr)*4+3], ram[int'(bus.lsu_o_ram_addr)*4+2],
                           ram[int'(bus.lsu_o_ram_addr)*4+1], ram[int'(bus.lsu_o_ram_addr)*4+0]};
         end
      end
   end

   assign {bus.lsu_i_ram_rdat3, bus.lsu_i_ram_rdat2,
           bus.lsu_i_ram_rdat1, bus.lsu_i_ram_rdat0} = ram_rdat_q;

   // Record every RAM cycle the unit drives.
   always @(negedge clk) begin
      if (bus.lsu_o_ram_cs) begin
         mon_c.addr = bus.lsu_o_ram_addr;
         mon_c.wen  = bus.lsu_o_ram_wen;
         mon_c.mask = bus.lsu_o_ram_mask;
         mon_c.wdat = {bus.lsu_o_ram_wdat3, bus.lsu_o_ram_wdat2,
                       bus.lsu_o_ram_wdat1, bus.lsu_o_ram_wdat0};
         trace.push_back(mon_c);
      end
   end

   function automatic logic [63:0] ramOut();
      return 64'({bus.lsu_o_ram_cs, bus.lsu_o_ram_wen, bus.lsu_o_ram_mask, bus.lsu_o_ram_addr,
                  bus.lsu_o_ram_wdat3, bus.lsu_o_ram_wdat2, bus.lsu_o_ram_wdat1, bus.lsu_o_ram_wdat0});
   endfunction

   function automatic int nBytes(input logic [1:0] size);
      return (size == XF100_LSU_SIZE_B) ? 1 : (size == XF100_LSU_SIZE_H) ? 2 : 4;
   endfunction

   // Reference load: gather bytes little-endian with address wrap, then extend.
   function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
      logic [31:0] v;
      int n;
      v = 32'h0;
      n = nBytes(size);
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = ref_mem[(int'(addr[AW+1:0]) + i) % MEMB];
      if (!uns && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
      if (!uns && n == 2 && v[15]) v[31:16] = 16'hFFFF;
      return v;
   endfunction

   task automatic refStore(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
      for (int i = 0; i < nBytes(size); i++)
         ref_mem[(int'(addr[AW+1:0]) + i) % MEMB] = wdata[8*i +: 8];
   endtask

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkTrace(input int idx, input string tag, input logic [AW-1:0] a,
                             input logic w, input logic [3:0] m, input logic [31:0] d,
                             input bit full);
      if (idx >= trace.size()) begin
         checkValue({tag, "_present"}, 64'(trace.size()), 64'(idx + 1));
      end else if (full) begin
         checkValue(tag, 64'(trace[idx]), 64'({a, w, m, d}));
      end else begin
         checkValue(tag, 64'({trace[idx].addr, trace[idx].wen}), 64'({a, w}));
      end
   endtask

   // Drive one request for a single cycle; queue its expected response.
   task automatic applyStimulus(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit want_rsp);
      exp_t e;
      bit   split;
      @(negedge clk);
      checkValue("req_ready", 64'(bus.lsu_o_ready), 64'd1);
      bus.lsu_i_valid    = 1'b1;
      bus.lsu_i_wen      = wen;
      bus.lsu_i_size     = size;
      bus.lsu_i_unsigned = uns;
      bus.lsu_i_addr     = addr;
      bus.lsu_i_wdata    = wdata;
      t_acc = cyc;
      split = ((size == XF100_LSU_SIZE_H) && (addr[1:0] == 2'd3)) ||
              ((size == XF100_LSU_SIZE_W) && (addr[1:0] != 2'd0));
      if (want_rsp) begin
         if (size == XF100_LSU_SIZE_RSV) begin
            e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
         end else if (wen) begin
            refStore(size, addr, wdata);
            e.rdata = 32'h0; e.err = 1'b0; e.lat = split ? 3 : 2;
         end else begin
            e.rdata = refLoad(size, uns, addr); e.err = 1'b0; e.lat = split ? 4 : 3;
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.lsu_i_valid    = 1'b0;
      bus.lsu_i_wen      = 1'($urandom_range(0, 1));
      bus.lsu_i_size     = 2'($urandom_range(0, 3));
      bus.lsu_i_unsigned = 1'($urandom_range(0, 1));
      bus.lsu_i_addr     = $urandom();
      bus.lsu_i_wdata    = $urandom();
   endtask

   // Wait for the response, optionally stall it, then compare and consume.
   task automatic checkOutput(input int stall);
      exp_t e;
      int   n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.lsu_o_rsp_valid && n < 20);
      e = sb.pop_front();
      checkValue("rsp_valid", 64'(bus.lsu_o_rsp_valid), 64'd1);
      if (!bus.lsu_o_rsp_valid) return;
      checkValue("rsp_latency", 64'(cyc - t_acc), 64'(e.lat));
      for (int s = 0; s < stall; s++) begin
         checkValue("stall_valid", 64'(bus.lsu_o_rsp_valid), 64'd1);
         checkValue("stall_rdata", 64'(bus.lsu_o_rsp_rdata), 64'(e.rdata));
         checkValue("stall_ready", 64'(bus.lsu_o_ready), 64'd0);
         @(negedge clk);
      end
      checkValue("rsp_rdata", 64'(bus.lsu_o_rsp_rdata), 64'(e.rdata));
      checkValue("rsp_err", 64'(bus.lsu_o_rsp_err), 64'(e.err));
      bus.lsu_i_rsp_ready = 1'b1;
      bus.lsu_i_valid     = 1'b0;
      @(posedge clk);
      #1;
      bus.lsu_i_rsp_ready = 1'b0;
      @(negedge clk);
      checkValue("post_rsp_idle", 64'({bus.lsu_o_ready, bus.lsu_o_rsp_valid}), 64'(2'b10));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.lsu_i_valid     = 1'b0;
      bus.lsu_i_wen       = 1'b0;
      bus.lsu_i_size      = 2'd0;
      bus.lsu_i_unsigned  = 1'b0;
      bus.lsu_i_addr      = 32'h0;
      bus.lsu_i_wdata     = 32'h0;
      bus.lsu_i_rsp_ready = 1'b0;
      rst_n    = 1'b0;
      mem_init = 1'b1;
      for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      mem_init = 1'b0;
      @(negedge clk);
      $display("[TB] reset values");
      checkValue("reset_rsp", 64'({bus.lsu_o_ready, bus.lsu_o_rsp_valid, bus.lsu_o_rsp_err,
                                   bus.lsu_o_rsp_rdata}), 64'({3'b100, 32'h0}));
      checkValue("reset_ram", ramOut(), 64'h0);

      $display("[TB] aligned word store and load");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_W, 1'b0, 32'h10, 32'h12345678, 1'b1);
      checkOutput(0);
      checkValue("sw_count", 64'(trace.size()), 64'd1);
      checkTrace(0, "sw_cyc", AW'(4), 1'b1, 4'hF, 32'h12345678, 1'b1);
      trace.delete();
      applyStimulus(1'b0, XF100_LSU_SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1);
      checkOutput(0);
      checkTrace(0, "lw_cyc", AW'(4), 1'b0, 4'h0, 32'h0, 1'b0);

      $display("[TB] byte store, signed and unsigned byte loads");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_B, 1'b0, 32'h13, 32'hFFFFFF80, 1'b1);
      checkOutput(0);
      checkTrace(0, "sb_cyc", AW'(4), 1'b1, 4'h8, 32'h80000000, 1'b1);
      applyStimulus(1'b0, XF100_LSU_SIZE_B, 1'b0, 32'h13, 32'h0, 1'b1);
      checkOutput(0);
      applyStimulus(1'b0, XF100_LSU_SIZE_B, 1'b1, 32'h13, 32'h0, 1'b1);
      checkOutput(0);

      $display("[TB] split word stores and loads");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_W, 1'b0, 32'h0D, 32'hAABBCCDD, 1'b1);
      checkOutput(0);
      checkValue("sw_split_count", 64'(trace.size()), 64'd2);
      checkTrace(0, "sw_split_c0", AW'(3), 1'b1, 4'hE, 32'hBBCCDD00, 1'b1);
      checkTrace(1, "sw_split_c1", AW'(4), 1'b1, 4'h1, 32'h000000AA, 1'b1);
      applyStimulus(1'b0, XF100_LSU_SIZE_W, 1'b0, 32'h0D, 32'h0, 1'b1);
      checkOutput(0);
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_W, 1'b0, 32'h0F, 32'hAABBCCDD, 1'b1);
      checkOutput(0);
      checkTrace(0, "sw_off3_c0", AW'(3), 1'b1, 4'h8, 32'hDD000000, 1'b1);
      checkTrace(1, "sw_off3_c1", AW'(4), 1'b1, 4'h7, 32'h00AABBCC, 1'b1);
      applyStimulus(1'b0, XF100_LSU_SIZE_W, 1'b0, 32'h0F, 32'h0, 1'b1);
      checkOutput(0);
      applyStimulus(1'b0, XF100_LSU_SIZE_H, 1'b0, 32'h0F, 32'h0, 1'b1);
      checkOutput(0);
      applyStimulus(1'b0, XF100_LSU_SIZE_H, 1'b0, 32'h12, 32'h0, 1'b1);
      checkOutput(0);

      $display("[TB] half store wrapping past the top word");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_H, 1'b0, 32'(MEMB - 1), 32'h1234BEEF, 1'b1);
      checkOutput(0);
      checkTrace(0, "wrap_c0", AW'((1 << AW) - 1), 1'b1, 4'h8, 32'hEF000000, 1'b1);
      checkTrace(1, "wrap_c1", AW'(0), 1'b1, 4'h1, 32'h000000BE, 1'b1);
      trace.delete();
      applyStimulus(1'b0, XF100_LSU_SIZE_H, 1'b1, 32'(MEMB - 1), 32'h0, 1'b1);
      checkOutput(0);
      checkTrace(1, "wrap_ld_c1", AW'(0), 1'b0, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, XF100_LSU_SIZE_H, 1'b0, 32'(MEMB - 1), 32'h0, 1'b1);
      checkOutput(0);

      $display("[TB] response backpressure");
      trace.delete();
      applyStimulus(1'b0, XF100_LSU_SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1);
      bus.lsu_i_valid = 1'b1;
      bus.lsu_i_wen   = 1'b1;
      bus.lsu_i_size  = XF100_LSU_SIZE_W;
      bus.lsu_i_addr  = 32'h80;
      bus.lsu_i_wdata = 32'hCAFEF00D;
      checkOutput(5);
      checkValue("bp_count", 64'(trace.size()), 64'd1);

      $display("[TB] reserved size");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_RSV, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1);
      checkOutput(0);
      applyStimulus(1'b0, XF100_LSU_SIZE_RSV, 1'b0, 32'h13, 32'h0, 1'b1);
      checkOutput(0);
      checkValue("rsv_count", 64'(trace.size()), 64'd0);

      $display("[TB] reset during a split store");
      trace.delete();
      applyStimulus(1'b1, XF100_LSU_SIZE_W, 1'b0, 32'h21, 32'h11223344, 1'b0);
      @(negedge clk);
      checkValue("mid_acc0_cs", 64'(bus.lsu_o_ram_cs), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkValue("mid_rst_ram", ramOut(), 64'h0);
      checkValue("mid_rst_rsp", 64'({bus.lsu_o_rsp_valid, bus.lsu_o_rsp_err,
                                     bus.lsu_o_rsp_rdata}), 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkValue("mid_rst_count", 64'(trace.size()), 64'd1);
      checkTrace(0, "mid_rst_word0", AW'(8), 1'b1, 4'hE, 32'h22334400, 1'b1);
      ref_mem[32'h21] = 8'h44;
      ref_mem[32'h22] = 8'h33;
      ref_mem[32'h23] = 8'h22;
      applyStimulus(1'b0, XF100_LSU_SIZE_W, 1'b0, 32'h21, 32'h0, 1'b1);
      checkOutput(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
